// File: rtl/demux_2_stream.sv
// demux_2_stream: 1-to-2 valid/ready stream demultiplexer.
// Each output has a single registered slot. Routing is fixed for a whole
// burst of BURST_LEN beats. The route is either taken from sel (manual mode)
// or alternates between bursts (auto ping-pong mode).
module demux_2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  sel,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out0_valid,
  output logic [DATA_WIDTH-1:0] out0_data,
  input  logic                  out0_ready,
  output logic                  out1_valid,
  output logic [DATA_WIDTH-1:0] out1_data,
  input  logic                  out1_ready,
  output logic                  cur_sel,
  output logic                  burst_done
);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BURST_LEN - 1);

  logic [CNT_WIDTH-1:0] cnt;
  logic                 eff_sel;
  logic                 accept;
  logic                 last_beat;
  logic                 wr0;
  logic                 wr1;

  // Effective target, ready for the selected slot only, and slot write strobes.
  // In manual mode, sel is consulted only on the first beat of a burst.
  always_comb begin
    eff_sel   = (!mode && (cnt == '0)) ? sel : cur_sel;
    in_ready  = eff_sel ? (!out1_valid || out1_ready)
                        : (!out0_valid || out0_ready);
    accept    = in_valid && in_ready;
    last_beat = (cnt == LAST_BEAT);
    wr0       = accept && !eff_sel;
    wr1       = accept && eff_sel;
  end

  // out0 slot: a write takes priority over a drain; data holds while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (wr0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  // out1 slot: a write takes priority over a drain; data holds while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (wr1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

  // Beat counter, registered route and end-of-burst pulse.
  // Auto mode flips the route only on the last beat of a burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      cur_sel    <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= accept && last_beat;
      if (accept) begin
        if (last_beat) begin
          cnt     <= '0;
          cur_sel <= mode ? ~eff_sel : eff_sel;
        end else begin
          cnt     <= cnt + 1'b1;
          cur_sel <= eff_sel;
        end
      end
    end
  end

endmodule
